regfile_write_arbiter: RTL and testbench

Owns the single write port of the pipeline register file and shares it between two requesters: the writeback stage (highest priority, never stalled) and an auxiliary requester with a valid/ready handshake (debug/load-multiple path). It also runs a clear-all sequencer that zeroes every register through the register file's `sclr` input, one index per cycle. It sits between WB and the register file and drives `regWrite`, `sclr`, `writeRegister` and `writeData` from registered outputs.

---
 rtl/regfile_write_arbiter.sv | 126 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the pipeline register file: writeback > clear-all sweep > aux handshake.
// All register-file controls are registered; auxReady is the only combinational output.
module regfile_write_arbiter #(
    parameter int  WordLen   = 32,
    parameter int  WordCount = 15,
    localparam int AddrLen   = $clog2(WordCount)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wbValid,
    input  logic [AddrLen-1:0] wbDest,
    input  logic [WordLen-1:0] wbData,
    input  logic               auxValid,
    output logic               auxReady,
    input  logic [AddrLen-1:0] auxDest,
    input  logic [WordLen-1:0] auxData,
    input  logic               clrStart,
    output logic               clrBusy,
    output logic               clrDone,
    output logic               rfWrite,
    output logic               rfSclr,
    output logic [AddrLen-1:0] rfWriteRegister,
    output logic [WordLen-1:0] rfWriteData,
    output logic [7:0]         conflictCount
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [AddrLen:0]   COUNT = (AddrLen + 1)'(WordCount);
    localparam logic [AddrLen-1:0] LAST  = AddrLen'(WordCount - 1);

    state_t             state, state_next;
    logic [AddrLen-1:0] idx, idx_next;

    logic               write_next, sclr_next, done_next, busy_next;
    logic [AddrLen-1:0] reg_next;
    logic [WordLen-1:0] data_next;
    logic [7:0]         count_next;

    logic wb_ok, aux_ok, aux_fire, clear_step, stall;

    assign wb_ok      = {1'b0, wbDest} < COUNT;
    assign aux_ok     = {1'b0, auxDest} < COUNT;
    assign auxReady   = (state == IDLE) && !wbValid && !clrStart;
    assign aux_fire   = auxValid && auxReady;
    // A writeback in CLEAR takes the port; the sweep index simply waits.
    assign clear_step = (state == CLEAR) && !wbValid;
    assign stall      = auxValid && !auxReady;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            idx             <= '0;
            rfWrite         <= 1'b0;
            rfSclr          <= 1'b0;
            clrBusy         <= 1'b0;
            clrDone         <= 1'b0;
            rfWriteRegister <= '0;
            rfWriteData     <= '0;
            conflictCount   <= '0;
        end else begin
            state           <= state_next;
            idx             <= idx_next;
            rfWrite         <= write_next;
            rfSclr          <= sclr_next;
            clrBusy         <= busy_next;
            clrDone         <= done_next;
            rfWriteRegister <= reg_next;
            rfWriteData     <= data_next;
            conflictCount   <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (clrStart) begin
                    state_next = CLEAR;
                    idx_next   = '0;
                end
            end
            CLEAR: begin
                if (clear_step) begin
                    if (idx == LAST) begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_comb begin
        write_next = 1'b0;
        sclr_next  = 1'b0;
        done_next  = 1'b0;
        reg_next   = rfWriteRegister;
        data_next  = rfWriteData;
        if (wbValid) begin
            if (wb_ok) begin
                write_next = 1'b1;
                reg_next   = wbDest;
                data_next  = wbData;
            end
        end else if (clear_step) begin
            sclr_next = 1'b1;
            reg_next  = idx;
            done_next = (idx == LAST);
        end else if (aux_fire && aux_ok) begin
            write_next = 1'b1;
            reg_next   = auxDest;
            data_next  = auxData;
        end
        busy_next  = (state_next == CLEAR);
        count_next = (stall && conflictCount != 8'hFF) ? conflictCount + 8'd1 : conflictCount;
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised and directed bench for regfile_write_arbiter against a queue-based sweep model
// and a register-file image that commits on the falling edge.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wbValid = 1'b0;
    logic [3:0]  wbDest = '0;
    logic [31:0] wbData = '0;
    logic        auxValid = 1'b0;
    logic        auxReady;
    logic [3:0]  auxDest = '0;
    logic [31:0] auxData = '0;
    logic        clrStart = 1'b0;
    logic        clrBusy, clrDone, rfWrite, rfSclr;
    logic [3:0]  rfWriteRegister;
    logic [31:0] rfWriteData;
    logic [7:0]  conflictCount;

    regfile_write_arbiter #(.WordLen(32), .WordCount(15)) dut (
        .clk(clk), .rst(rst),
        .wbValid(wbValid), .wbDest(wbDest), .wbData(wbData),
        .auxValid(auxValid), .auxReady(auxReady), .auxDest(auxDest), .auxData(auxData),
        .clrStart(clrStart), .clrBusy(clrBusy), .clrDone(clrDone),
        .rfWrite(rfWrite), .rfSclr(rfSclr),
        .rfWriteRegister(rfWriteRegister), .rfWriteData(rfWriteData),
        .conflictCount(conflictCount)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Register file as seen by the DUT: commits on the falling edge.
    logic [31:0] rf [15] = '{default: '0};
    always @(negedge clk) begin
        if (rst && rfWriteRegister < 4'd15) begin
            if (rfWrite) rf[rfWriteRegister] <= rfWriteData;
            else if (rfSclr) rf[rfWriteRegister] <= '0;
        end
    end

    // Reference model: the sweep is a queue of indices still to be cleared.
    logic [31:0] exp_rf [15] = '{default: '0};
    int          sweep_q[$];
    bit          m_write, m_sclr, m_done, m_aux_taken;
    logic [3:0]  m_reg;
    logic [31:0] m_data;
    int          m_count;

    logic [47:0] obs;
    assign obs = {rfWrite, rfSclr, clrBusy, clrDone, rfWriteRegister, conflictCount, rfWriteData};

    function automatic logic [47:0] exp_vec();
        return {m_write, m_sclr, sweep_q.size() != 0, m_done, m_reg, 8'(m_count), m_data};
    endfunction

    function automatic bit exp_ready();
        return sweep_q.size() == 0 && !wbValid && !clrStart;
    endfunction

    function automatic void model_reset();
        sweep_q.delete();
        m_write = 0; m_sclr = 0; m_done = 0; m_aux_taken = 0;
        m_reg = '0; m_data = '0; m_count = 0;
    endfunction

    function automatic void model_edge();
        bit busy  = sweep_q.size() != 0;
        bit ready = !busy && !wbValid && !clrStart;
        m_aux_taken = auxValid && ready;
        if (auxValid && !ready && m_count < 255) m_count++;
        m_write = 0; m_sclr = 0; m_done = 0;
        if (wbValid) begin
            if (wbDest < 15) begin m_write = 1; m_reg = wbDest; m_data = wbData; end
        end else if (busy) begin
            m_sclr = 1;
            m_reg  = 4'(sweep_q.pop_front());
            m_done = sweep_q.size() == 0;
        end else if (m_aux_taken && auxDest < 15) begin
            m_write = 1; m_reg = auxDest; m_data = auxData;
        end
        if (!busy && clrStart)
            for (int i = 0; i < 15; i++) sweep_q.push_back(i);
        if (m_write) exp_rf[m_reg] = m_data;
        else if (m_sclr) exp_rf[m_reg] = '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic idle_inputs();
        wbValid = 0; auxValid = 0; clrStart = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (obs !== 48'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, 48'd0); end
        n_cmp++;
        if (auxReady !== 1'b1) begin n_fail++; $display("FAIL reset_aux_ready: got %b expected 1", auxReady); end
        release_reset();
    endtask

    task automatic test_preload();
        for (int i = 0; i < 15; i++) begin
            wbValid = 1; wbDest = 4'(i); wbData = $urandom | 32'h1;
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL preload_out: got %h expected %h", obs, exp_vec()); end
        end
        wbValid = 0;
        @(negedge clk); #1;
        for (int i = 0; i < 15; i++) begin
            n_cmp++;
            if (rf[i] !== exp_rf[i]) begin n_fail++; $display("FAIL preload_rf%0d: got %h expected %h", i, rf[i], exp_rf[i]); end
        end
    endtask

    task automatic test_aux_basic();
        wbValid = 1; wbDest = 4'd1; wbData = 32'h5555; auxValid = 1; auxDest = 4'd8;
        tick();
        do_reset();
        n_cmp++;
        if (obs !== 48'd0) begin n_fail++; $display("FAIL async_reset: got %h expected %h", obs, 48'd0); end
        idle_inputs();
        release_reset();
        auxValid = 1; auxDest = 4'd3; auxData = 32'hA5;
        #1;
        n_cmp++;
        if (auxReady !== 1'b1) begin n_fail++; $display("FAIL aux_ready_idle: got %b expected 1", auxReady); end
        tick();
        n_cmp++;
        if (obs !== exp_vec()) begin n_fail++; $display("FAIL aux_write_out: got %h expected %h", obs, exp_vec()); end
        auxValid = 0;
        @(negedge clk); #1;
        n_cmp++;
        if (rf[3] !== 32'hA5) begin n_fail++; $display("FAIL aux_reg3: got %h expected %h", rf[3], 32'hA5); end
    endtask

    task automatic test_wb_aux_conflict();
        wbValid = 1; wbDest = 4'd2; wbData = 32'h11;
        auxValid = 1; auxDest = 4'd4; auxData = 32'h22;
        #1;
        n_cmp++;
        if (auxReady !== 1'b0) begin n_fail++; $display("FAIL conflict_ready: got %b expected 0", auxReady); end
        tick();
        n_cmp++;
        if (obs !== exp_vec()) begin n_fail++; $display("FAIL conflict_wb_out: got %h expected %h", obs, exp_vec()); end
        n_cmp++;
        if (conflictCount !== 8'd1) begin n_fail++; $display("FAIL conflict_count: got %0d expected 1", conflictCount); end
        wbValid = 0;
        tick();
        n_cmp++;
        if (obs !== exp_vec()) begin n_fail++; $display("FAIL conflict_aux_out: got %h expected %h", obs, exp_vec()); end
        auxValid = 0;
        @(negedge clk); #1;
        n_cmp++;
        if (rf[2] !== 32'h11 || rf[4] !== 32'h22) begin
            n_fail++; $display("FAIL conflict_rf: got %h/%h expected 11/22", rf[2], rf[4]);
        end
    endtask

    task automatic test_clear_sweep();
        int busy_cycles = 0;
        clrStart = 1;
        tick();
        clrStart = 0;
        if (clrBusy) busy_cycles++;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (clrBusy) busy_cycles++;
            n_cmp++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL sweep_out%0d: got %h expected %h", i, obs, exp_vec()); end
            n_cmp++;
            if (rfSclr !== 1'b1 || rfWriteRegister !== 4'(i) || clrDone !== (i == 14)) begin
                n_fail++; $display("FAIL sweep_step%0d: got sclr=%b idx=%0d done=%b", i, rfSclr, rfWriteRegister, clrDone);
            end
        end
        tick();
        n_cmp++;
        if (clrDone !== 1'b0 || rfSclr !== 1'b0) begin n_fail++; $display("FAIL sweep_end: got done=%b sclr=%b expected 0/0", clrDone, rfSclr); end
        n_cmp++;
        if (busy_cycles != 15) begin n_fail++; $display("FAIL sweep_busy_len: got %0d expected 15", busy_cycles); end
        @(negedge clk); #1;
        for (int i = 0; i < 15; i++) begin
            n_cmp++;
            if (rf[i] !== 32'd0) begin n_fail++; $display("FAIL sweep_rf%0d: got %h expected 0", i, rf[i]); end
        end
    endtask

    task automatic test_clear_with_wb();
        int done_at = 0;
        int sclr_n  = 0;
        clrStart = 1;
        tick();
        clrStart = 0;
        for (int j = 1; j <= 40 && done_at == 0; j++) begin
            wbValid = (j == 3 || j == 4); wbDest = 4'd9; wbData = $urandom | 32'h1;
            tick();
            if (rfSclr) sclr_n++;
            n_cmp++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL sweepwb_out%0d: got %h expected %h", j, obs, exp_vec()); end
            if (clrDone) done_at = j;
        end
        wbValid = 0;
        n_cmp++;
        if (done_at != 17 || sclr_n != 15) begin n_fail++; $display("FAIL sweepwb_len: got %0d/%0d expected 17/15", done_at, sclr_n); end
        @(negedge clk); #1;
        n_cmp++;
        if (rf[9] !== 32'd0) begin n_fail++; $display("FAIL sweepwb_reg9: got %h expected 0", rf[9]); end
    endtask

    task automatic test_aux_during_sweep();
        int taken_at = 0;
        do_reset();
        release_reset();
        auxValid = 1; auxDest = 4'd5; auxData = $urandom;
        clrStart = 1;
        #1;
        n_cmp++;
        if (auxReady !== 1'b0) begin n_fail++; $display("FAIL sweepaux_ready0: got %b expected 0", auxReady); end
        tick();
        clrStart = 0;
        for (int e = 1; e <= 40 && taken_at == 0; e++) begin
            #1;
            n_cmp++;
            if (auxReady !== exp_ready()) begin n_fail++; $display("FAIL sweepaux_ready%0d: got %b expected %b", e, auxReady, exp_ready()); end
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL sweepaux_out%0d: got %h expected %h", e, obs, exp_vec()); end
            if (m_aux_taken) taken_at = e;
        end
        auxValid = 0;
        n_cmp++;
        if (taken_at != 16 || conflictCount !== 8'd16) begin
            n_fail++; $display("FAIL sweepaux_accept: got edge %0d count %0d expected 16/16", taken_at, conflictCount);
        end
    endtask

    task automatic test_saturation();
        auxValid = 1; auxDest = 4'd6; auxData = $urandom;
        for (int i = 0; i < 300; i++) begin
            wbValid = 1; wbDest = 4'($urandom_range(0, 14)); wbData = $urandom;
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL sat_out%0d: got %h expected %h", i, obs, exp_vec()); end
        end
        n_cmp++;
        if (conflictCount !== 8'd255) begin n_fail++; $display("FAIL sat_count: got %0d expected 255", conflictCount); end
        wbValid = 0;
        tick();
        n_cmp++;
        if (!m_aux_taken || obs !== exp_vec()) begin n_fail++; $display("FAIL sat_release: got %h expected %h", obs, exp_vec()); end
        auxValid = 0;
    endtask

    task automatic test_bad_dest();
        auxValid = 1; auxDest = 4'd15; auxData = 32'hDEAD;
        #1;
        n_cmp++;
        if (auxReady !== 1'b1) begin n_fail++; $display("FAIL baddest_ready: got %b expected 1", auxReady); end
        tick();
        auxValid = 0;
        n_cmp++;
        if (rfWrite !== 1'b0 || obs !== exp_vec()) begin n_fail++; $display("FAIL baddest_aux: got %h expected %h", obs, exp_vec()); end
        wbValid = 1; wbDest = 4'd15; wbData = 32'hBEEF;
        tick();
        wbValid = 0;
        n_cmp++;
        if (rfWrite !== 1'b0 || obs !== exp_vec()) begin n_fail++; $display("FAIL baddest_wb: got %h expected %h", obs, exp_vec()); end
        @(negedge clk); #1;
        for (int i = 0; i < 15; i++) begin
            n_cmp++;
            if (rf[i] !== exp_rf[i]) begin n_fail++; $display("FAIL baddest_rf%0d: got %h expected %h", i, rf[i], exp_rf[i]); end
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic [31:0] saved [15];
        bool_wait: begin end
        for (int i = 7; i < 15; i++) begin
            wbValid = 1; wbDest = 4'(i); wbData = $urandom | 32'h1;
            tick();
        end
        wbValid = 0;
        clrStart = 1;
        tick();
        clrStart = 0;
        for (int i = 0; i < 40 && !(sweep_q.size() != 0 && sweep_q[0] == 7); i++) tick();
        n_cmp++;
        if (rfWriteRegister !== 4'd6 || rfSclr !== 1'b1) begin
            n_fail++; $display("FAIL midreset_pos: got idx=%0d sclr=%b expected 6/1", rfWriteRegister, rfSclr);
        end
        do_reset();
        for (int i = 0; i < 15; i++) saved[i] = exp_rf[i];
        n_cmp++;
        if (obs !== 48'd0) begin n_fail++; $display("FAIL midreset_out: got %h expected %h", obs, 48'd0); end
        release_reset();
        repeat (3) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec() || rfSclr !== 1'b0) begin n_fail++; $display("FAIL midreset_after: got %h expected %h", obs, exp_vec()); end
        end
        @(negedge clk); #1;
        for (int i = 7; i < 15; i++) begin
            n_cmp++;
            if (rf[i] !== saved[i] || rf[i] === 32'd0) begin n_fail++; $display("FAIL midreset_rf%0d: got %h expected %h", i, rf[i], saved[i]); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            wbValid = ($urandom_range(0, 3) == 0);
            wbDest  = 4'($urandom_range(0, 15));
            wbData  = $urandom;
            if (!auxValid && $urandom_range(0, 1) == 1) begin
                auxValid = 1; auxDest = 4'($urandom_range(0, 15)); auxData = $urandom;
            end
            clrStart = ($urandom_range(0, 40) == 0);
            #1;
            n_cmp++;
            if (auxReady !== exp_ready()) begin n_fail++; $display("FAIL rand_ready%0d: got %b expected %b", c, auxReady, exp_ready()); end
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL rand_out%0d: got %h expected %h", c, obs, exp_vec()); end
            if (m_aux_taken) auxValid = 0;
        end
        idle_inputs();
        @(negedge clk); #1;
        for (int i = 0; i < 15; i++) begin
            n_cmp++;
            if (rf[i] !== exp_rf[i]) begin n_fail++; $display("FAIL rand_rf%0d: got %h expected %h", i, rf[i], exp_rf[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_aux_basic();
        test_wb_aux_conflict();
        test_clear_sweep();
        test_clear_with_wb();
        test_aux_during_sweep();
        test_saturation();
        test_bad_dest();
        test_reset_mid_sweep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
